multdiv_issue_ctrl: RTL and testbench

Sequencer that shares the multicycle multiply/divide unit with the single-cycle processor core. Sits between decode and the multdiv unit. On a `mul`/`div` it freezes fetch and latches the operands, then pulses the unit's start control. When the unit reports ready, it drives one regfile write: the result to `rd`, or an exception code to r30 (rstatus). It also bounds the wait with a timeout so the core can never hang.

---
 rtl/multdiv_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue_ctrl.sv
// Issue sequencer for the shared multicycle multiply/divide unit: freezes fetch,
// latches operands, pulses start, and performs one bounded regfile writeback.
module multdiv_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] MUL_EXC_CODE   = 32'd4,
    parameter logic [31:0] DIV_EXC_CODE   = 32'd5,
    parameter logic [31:0] TIMEOUT_CODE   = 32'd6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        stall,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_WB} state_e;

    localparam logic [4:0] RSTATUS_REG = 5'd30;
    localparam logic [7:0] CNT_LAST    = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        is_div_q;
    logic [4:0]  rd_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic        mult_q;
    logic        div_q;
    logic        wb_en_q;
    logic [4:0]  wb_reg_q;
    logic [31:0] wb_data_q;

    assign cnt_d = cnt_q + 8'd1;

    // NOTE: every register here is state, so all use non-blocking assignments;
    // outputs are registered and set on the transition into the state they belong to.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            rd_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            mult_q    <= 1'b0;
            div_q     <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue_valid) begin
                        is_div_q <= issue_is_div;
                        rd_q     <= issue_rd;
                        op_a_q   <= issue_a;
                        op_b_q   <= issue_b;
                        mult_q   <= ~issue_is_div;
                        div_q    <= issue_is_div;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    // md_ready may still be asserted from the previous op; not sampled here.
                    mult_q  <= 1'b0;
                    div_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_BUSY;
                end
                S_BUSY: begin
                    cnt_q <= cnt_d;
                    if (md_ready) begin
                        state_q <= S_WB;
                        if (md_exception) begin
                            wb_en_q   <= 1'b1;
                            wb_reg_q  <= RSTATUS_REG;
                            wb_data_q <= is_div_q ? DIV_EXC_CODE : MUL_EXC_CODE;
                        end else begin
                            wb_en_q   <= (rd_q != 5'd0);
                            wb_reg_q  <= rd_q;
                            wb_data_q <= md_result;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= S_WB;
                        wb_en_q   <= 1'b1;
                        wb_reg_q  <= RSTATUS_REG;
                        wb_data_q <= TIMEOUT_CODE;
                    end
                end
                S_WB: begin
                    wb_en_q   <= 1'b0;
                    wb_reg_q  <= '0;
                    wb_data_q <= '0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Control strobes are masked while reset is asserted so an aborted op emits nothing.
    assign md_ctrl_mult = mult_q & reset;
    assign md_ctrl_div  = div_q & reset;
    assign wb_en        = wb_en_q & reset;
    assign stall        = reset & (((state_q == S_IDLE) & issue_valid) |
                                   (state_q == S_START) | (state_q == S_BUSY));
    assign md_operand_a = op_a_q;
    assign md_operand_b = op_b_q;
    assign wb_reg       = wb_reg_q;
    assign wb_data      = wb_data_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl: table of single transactions plus
// hand sequences for back-to-back, reset abort and timeout.
module tb_multdiv_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_is_div = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] issue_a = '0;
    logic [31:0] issue_b = '0;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0;
    logic        md_ready = 1'b0;

    logic        md_ctrl_mult, md_ctrl_div, stall, wb_en, busy;
    logic [31:0] md_operand_a, md_operand_b, wb_data;
    logic [4:0]  wb_reg;

    logic        t8_md_ctrl_mult, t8_md_ctrl_div, t8_stall, t8_wb_en, t8_busy;
    logic [31:0] t8_md_operand_a, t8_md_operand_b, t8_wb_data;
    logic [4:0]  t8_wb_reg;

    int total = 0;
    int bad   = 0;

    multdiv_issue_ctrl dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
        .issue_a(issue_a), .issue_b(issue_b),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .stall(stall), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy)
    );

    multdiv_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut_t8 (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
        .issue_a(issue_a), .issue_b(issue_b),
        .md_ctrl_mult(t8_md_ctrl_mult), .md_ctrl_div(t8_md_ctrl_div),
        .md_operand_a(t8_md_operand_a), .md_operand_b(t8_md_operand_b),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .stall(t8_stall), .wb_en(t8_wb_en), .wb_reg(t8_wb_reg), .wb_data(t8_wb_data),
        .busy(t8_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_div;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        int          ready_at;   // BUSY cycle index (0 = first BUSY cycle) carrying md_ready
        logic        exc;
        logic [31:0] result;
        logic        exp_en;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one op from the IDLE-with-issue cycle through to the WB cycle (returns in WB).
    task automatic run_op(input vec_t v, input string id);
        logic done;
        issue_valid  = 1'b1;
        issue_is_div = v.is_div;
        issue_rd     = v.rd;
        issue_a      = v.a;
        issue_b      = v.b;
        md_ready     = 1'b0;
        md_exception = 1'b1;
        #1;
        check({id, "_idle_stall"}, 32'(stall), 32'd1);
        check({id, "_idle_busy"}, 32'(busy), 32'd0);
        tick();
        md_ready  = 1'b1;
        md_result = 32'hBAD0_0001;
        #1;
        check({id, "_start_pulses"}, 32'({md_ctrl_mult, md_ctrl_div}), 32'({~v.is_div, v.is_div}));
        check({id, "_start_op_a"}, md_operand_a, v.a);
        check({id, "_start_op_b"}, md_operand_b, v.b);
        check({id, "_start_stall_wb"}, 32'({stall, wb_en}), 32'b10);
        tick();
        md_ready = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 70 && !done; n++) begin
            if (n == v.ready_at) begin
                md_ready     = 1'b1;
                md_exception = v.exc;
                md_result    = v.result;
            end
            #1;
            check($sformatf("%s_busy%0d_ctl", id, n),
                  32'({stall, wb_en, md_ctrl_mult, md_ctrl_div}), 32'b1000);
            check($sformatf("%s_busy%0d_op_a", id, n), md_operand_a, v.a);
            tick();
            if (n == v.ready_at) done = 1'b1;
            md_ready     = 1'b0;
            md_exception = 1'b1;
            md_result    = 32'hBAD0_0002;
        end
        check({id, "_wb_reached"}, 32'(done), 32'd1);
        check({id, "_wb_en"}, 32'(wb_en), 32'(v.exp_en));
        check({id, "_wb_stall_busy"}, 32'({stall, busy}), 32'b01);
        if (v.exp_en) begin
            check({id, "_wb_reg"}, 32'(wb_reg), 32'(v.exp_reg));
            check({id, "_wb_data"}, wb_data, v.exp_data);
        end
    endtask

    task automatic expect_idle(input string id);
        check({id, "_after_busy"}, 32'(busy), 32'd0);
        check({id, "_after_ctl"}, 32'({stall, wb_en, md_ctrl_mult, md_ctrl_div}), 32'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int count;
        //            div rd  a           b          rdy exc result        en reg  data
        vecs[0] = '{1'b0, 5'd5,  32'd7,   32'd6,      16, 1'b0, 32'h2A,       1'b1, 5'd5,  32'h2A};
        vecs[1] = '{1'b1, 5'd3,  32'd100, 32'd0,      31, 1'b1, 32'hDEAD,     1'b1, 5'd30, 32'd5};
        vecs[2] = '{1'b0, 5'd0,  32'd3,   32'd4,       2, 1'b0, 32'd12,       1'b0, 5'd0,  32'd0};
        vecs[3] = '{1'b0, 5'd9,  32'hFFFF,32'hFFFF,    0, 1'b1, 32'h1234,     1'b1, 5'd30, 32'd4};
        vecs[4] = '{1'b1, 5'd12, 32'd100, 32'd7,      63, 1'b0, 32'd14,       1'b1, 5'd12, 32'd14};
        vecs[5] = '{1'b0, 5'd31, 32'hFFFFFFFF, 32'd1, 62, 1'b0, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};

        // Reset with an issue pending: nothing may leak out.
        issue_valid = 1'b1;
        tick();
        tick();
        check("rst_ctl", 32'({stall, wb_en, md_ctrl_mult, md_ctrl_div, busy}), 32'b0);
        check("rst_wb_reg", 32'(wb_reg), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_op_a", md_operand_a, 32'd0);
        check("rst_op_b", md_operand_b, 32'd0);
        issue_valid = 1'b0;
        reset = 1'b1;
        tick();
        expect_idle("post_rst");

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i], $sformatf("v%0d", i));
            issue_valid = 1'b0;
            tick();
            expect_idle($sformatf("v%0d", i));
        end

        // Back-to-back mul then div: the div is held on issue during WB and taken next cycle.
        run_op('{1'b0, 5'd4, 32'd5, 32'd9, 1, 1'b0, 32'd45, 1'b1, 5'd4, 32'd45}, "b2b_mul");
        issue_is_div = 1'b1;
        issue_rd     = 5'd8;
        issue_a      = 32'd81;
        issue_b      = 32'd9;
        tick();
        check("b2b_idle_busy", 32'(busy), 32'd0);
        run_op('{1'b1, 5'd8, 32'd81, 32'd9, 3, 1'b0, 32'd9, 1'b1, 5'd8, 32'd9}, "b2b_div");
        issue_valid = 1'b0;
        tick();
        expect_idle("b2b_div");

        // Reset in the middle of BUSY, then a late ready must not write.
        issue_valid  = 1'b1;
        issue_is_div = 1'b0;
        issue_rd     = 5'd6;
        issue_a      = 32'd2;
        issue_b      = 32'd3;
        md_exception = 1'b0;
        tick();
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("midrst_ctl", 32'({stall, wb_en, md_ctrl_mult, md_ctrl_div, busy}), 32'b0);
        check("midrst_op_a", md_operand_a, 32'd0);
        check("midrst_wb", 32'({wb_reg, wb_data}), 32'd0);
        reset       = 1'b1;
        issue_valid = 1'b0;
        md_ready    = 1'b1;
        md_result   = 32'd99;
        for (int n = 0; n < 3; n++) begin
            #1;
            check($sformatf("midrst_late%0d", n), 32'({wb_en, busy}), 32'b0);
            tick();
        end
        md_ready = 1'b0;
        run_op('{1'b0, 5'd6, 32'd2, 32'd3, 3, 1'b0, 32'd6, 1'b1, 5'd6, 32'd6}, "post_midrst");
        issue_valid = 1'b0;
        tick();
        expect_idle("post_midrst");

        // Timeout on the 8-cycle instance, with a stale ready present during START.
        reset = 1'b0;
        tick();
        reset        = 1'b1;
        issue_valid  = 1'b1;
        issue_is_div = 1'b0;
        issue_rd     = 5'd7;
        issue_a      = 32'd1;
        issue_b      = 32'd1;
        md_exception = 1'b0;
        #1;
        check("to_idle_stall", 32'(t8_stall), 32'd1);
        tick();
        md_ready = 1'b1;
        #1;
        check("to_start_pulse", 32'({t8_md_ctrl_mult, t8_md_ctrl_div}), 32'b10);
        tick();
        md_ready = 1'b0;
        count = 0;
        while (!t8_wb_en && count < 20) begin
            check($sformatf("to_busy%0d_stall", count), 32'(t8_stall), 32'd1);
            count++;
            tick();
        end
        check("to_busy_cycles", 32'(count), 32'd8);
        check("to_wb_en", 32'(t8_wb_en), 32'd1);
        check("to_wb_reg", 32'(t8_wb_reg), 32'd30);
        check("to_wb_data", t8_wb_data, 32'd6);
        check("to_wb_stall", 32'(t8_stall), 32'd0);
        issue_valid = 1'b0;
        tick();
        check("to_after_busy", 32'({t8_busy, t8_wb_en}), 32'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
